// File: rtl/p405s_icu_fill_rd.sv
// I-cache line fill buffer, read side: captures a critical-word-first 8-word fill,
// serves fetch reads of captured words (with same-edge bypass), then drains the line in order.
module p405s_icu_fill_rd (
  input  logic        CB,
  input  logic        RSTN,
  input  logic        FillStart,
  input  logic [0:2]  FillStartWd,
  input  logic        FillVal,
  input  logic [0:31] FillData,
  input  logic        FillErr,
  input  logic        RdReq,
  input  logic [0:2]  RdWd,
  output logic        RdAck,
  output logic [0:31] RdData,
  output logic        RdErr,
  output logic        ArrWe,
  output logic [0:2]  ArrWd,
  output logic [0:31] ArrData,
  output logic        Busy,
  output logic        LineDone,
  output logic        LineErr
);

  typedef enum logic [1:0] {StIdle, StFill, StDrain} state_e;

  state_e      state_q, state_d;
  logic [0:31] words_q [8];
  logic [7:0]  valid_q, valid_d;
  logic        err_q, err_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  drain_q, drain_d;
  logic        rd_ack_q, rd_ack_d;
  logic [0:31] rd_data_q, rd_data_d;
  logic        rd_err_q, rd_err_d;

  logic        fill_we;
  logic        err_now;
  logic        rd_byp;
  logic        line_done;
  logic        line_err;

  assign fill_we = (state_q == StFill) && FillVal;
  assign err_now = err_q | (FillVal & FillErr);

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    err_d     = err_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    line_done = 1'b0;
    line_err  = 1'b0;
    case (state_q)
      StIdle: begin
        if (FillStart) begin
          valid_d = '0;
          err_d   = 1'b0;
          ptr_d   = FillStartWd;
          cnt_d   = 4'd0;
          state_d = StFill;
        end
      end
      StFill: begin
        if (FillVal) begin
          valid_d[ptr_q] = 1'b1;
          err_d          = err_now;
          ptr_d          = ptr_q + 3'd1;
          cnt_d          = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            // An errored line is never written into the array.
            if (err_now) begin
              line_done = 1'b1;
              line_err  = 1'b1;
              state_d   = StIdle;
            end else begin
              drain_d = 3'd0;
              state_d = StDrain;
            end
          end
        end
      end
      StDrain: begin
        drain_d = drain_q + 3'd1;
        if (drain_q == 3'd7) begin
          line_done = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A word landing on this edge can be returned without waiting for its valid bit.
  always_comb begin
    rd_byp    = fill_we && (ptr_q == RdWd);
    rd_ack_d  = RdReq && (state_q != StIdle) && (valid_q[RdWd] || rd_byp);
    rd_data_d = rd_data_q;
    rd_err_d  = 1'b0;
    if (rd_ack_d) begin
      rd_data_d = rd_byp ? FillData : words_q[RdWd];
      rd_err_d  = err_q;
    end
  end

  always_ff @(posedge CB or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= StIdle;
      valid_q   <= '0;
      err_q     <= 1'b0;
      ptr_q     <= 3'd0;
      cnt_q     <= 4'd0;
      drain_q   <= 3'd0;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      rd_ack_q  <= rd_ack_d;
      rd_data_q <= rd_data_d;
      rd_err_q  <= rd_err_d;
    end
  end

  always_ff @(posedge CB) begin
    if (fill_we) begin
      words_q[ptr_q] <= FillData;
    end
  end

  assign RdAck    = rd_ack_q;
  assign RdData   = rd_data_q;
  assign RdErr    = rd_err_q;
  assign ArrWe    = (state_q == StDrain);
  assign ArrWd    = ArrWe ? drain_q : 3'd0;
  assign ArrData  = ArrWe ? words_q[drain_q] : '0;
  assign Busy     = (state_q != StIdle);
  assign LineDone = line_done;
  assign LineErr  = line_err;

endmodule

// File: tb/tb_p405s_icu_fill_rd.sv
// Scoreboard bench for p405s_icu_fill_rd: stimulus pushes expected reads, array writes and
// line completions tagged with a due cycle; a negedge monitor pops and compares them.
module tb_p405s_icu_fill_rd;

  logic        CB = 1'b0;
  logic        RSTN = 1'b0;
  logic        FillStart = 1'b0;
  logic [0:2]  FillStartWd = 3'd0;
  logic        FillVal = 1'b0;
  logic [0:31] FillData = '0;
  logic        FillErr = 1'b0;
  logic        RdReq = 1'b0;
  logic [0:2]  RdWd = 3'd0;
  logic        RdAck, RdErr, ArrWe, Busy, LineDone, LineErr;
  logic [0:31] RdData, ArrData;
  logic [0:2]  ArrWd;

  p405s_icu_fill_rd dut (
    .CB(CB), .RSTN(RSTN), .FillStart(FillStart), .FillStartWd(FillStartWd),
    .FillVal(FillVal), .FillData(FillData), .FillErr(FillErr), .RdReq(RdReq), .RdWd(RdWd),
    .RdAck(RdAck), .RdData(RdData), .RdErr(RdErr), .ArrWe(ArrWe), .ArrWd(ArrWd),
    .ArrData(ArrData), .Busy(Busy), .LineDone(LineDone), .LineErr(LineErr)
  );

  always #5 CB = ~CB;

  int cyc = 0;
  always @(posedge CB) cyc <= cyc + 1;

  typedef struct {int due; logic [31:0] data; logic err;} rd_exp_t;
  typedef struct {int due; int wd; logic [31:0] data;} arr_exp_t;
  typedef struct {int due; logic err;} ld_exp_t;

  rd_exp_t  rd_q[$];
  arr_exp_t arr_q[$];
  ld_exp_t  ld_q[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model of the line being filled.
  logic [31:0] mem [8];
  bit          arrived [8];
  bit          m_err = 1'b0;
  int          m_ptr = 0;
  int          m_cnt = 0;
  bit          fill_open = 1'b0;
  int          drain_left = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CB) begin
    rd_exp_t  re;
    arr_exp_t ae;
    ld_exp_t  le;
    if (!RSTN) begin
      check("rst_rdack", RdAck, 0);
      check("rst_rddata", RdData, 0);
      check("rst_rderr", RdErr, 0);
      check("rst_arrwe", ArrWe, 0);
      check("rst_arrwd", ArrWd, 0);
      check("rst_arrdata", ArrData, 0);
      check("rst_busy", Busy, 0);
      check("rst_linedone", LineDone, 0);
      check("rst_lineerr", LineErr, 0);
    end else begin
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        re = rd_q.pop_front();
        check("rd_ack", RdAck, 1);
        check("rd_data", RdData, re.data);
        check("rd_err", RdErr, re.err);
      end else begin
        check("rd_noack", RdAck, 0);
      end
      if (arr_q.size() > 0 && arr_q[0].due == cyc) begin
        ae = arr_q.pop_front();
        check("arr_we", ArrWe, 1);
        check("arr_wd", ArrWd, ae.wd);
        check("arr_data", ArrData, ae.data);
      end else begin
        check("arr_nowe", ArrWe, 0);
      end
      if (ld_q.size() > 0 && ld_q[0].due == cyc) begin
        le = ld_q.pop_front();
        check("line_done", LineDone, 1);
        check("line_err", LineErr, le.err);
      end else begin
        check("line_nodone", LineDone, 0);
      end
      check("busy", Busy, (fill_open || drain_left > 0) ? 1 : 0);
    end
  end

  // One clock of stimulus; called just after a rising edge.
  task automatic step(bit fv, logic [31:0] fd, bit fe, bit fs, int fsw, bit rq, int rwd);
    bit busy_now;
    int c0;
    c0 = cyc;
    busy_now = fill_open || drain_left > 0;
    FillVal = fv; FillData = fd; FillErr = fe; FillStart = fs;
    FillStartWd = 3'(fsw); RdReq = rq; RdWd = 3'(rwd);
    if (rq && busy_now) begin
      if (arrived[rwd]) rd_q.push_back('{c0 + 1, mem[rwd], m_err});
      else if (fill_open && fv && m_ptr == rwd) rd_q.push_back('{c0 + 1, fd, m_err});
    end
    if (fill_open && fv && m_cnt == 7 && (m_err || fe)) ld_q.push_back('{c0, 1'b1});
    @(posedge CB);
    if (drain_left > 0) drain_left--;
    if (!busy_now) begin
      if (fs) begin
        foreach (arrived[i]) arrived[i] = 1'b0;
        m_err = 1'b0; m_ptr = fsw; m_cnt = 0; fill_open = 1'b1;
      end
    end else if (fill_open && fv) begin
      mem[m_ptr] = fd; arrived[m_ptr] = 1'b1; m_err = m_err | fe;
      m_ptr = (m_ptr + 1) % 8; m_cnt++;
      if (m_cnt == 8) begin
        fill_open = 1'b0;
        if (!m_err) begin
          for (int i = 0; i < 8; i++) arr_q.push_back('{c0 + 1 + i, i, mem[i]});
          ld_q.push_back('{c0 + 8, 1'b0});
          drain_left = 8;
        end
      end
    end
    #1;
  endtask

  task automatic idle_step(bit noise_fs, int rd_fix);
    bit rq;
    int rwd;
    rq = (rd_fix != -1) ? 1'b1 : 1'($urandom % 2);
    rwd = (rd_fix >= 0) ? rd_fix : (rd_fix == -2) ? cyc % 8 : int'($urandom % 8);
    step(0, $urandom, 1'($urandom % 2), noise_fs && ($urandom % 3 == 0), $urandom % 8, rq, rwd);
  endtask

  // gap < 0 means random gaps; rd_fix: -1 random reads, -2 sweep indices, else fixed index.
  task automatic fill(int s, bit directed, int err_pos, int gap, int rd_fix, bit fs_noise,
                      int stop_after);
    logic [31:0] d;
    int ng;
    int rwd;
    step(0, 0, 0, 1, s, 1'($urandom % 2), $urandom % 8);
    for (int i = 0; i < 8; i++) begin
      if (i == stop_after) return;
      ng = (gap >= 0) ? gap : int'($urandom_range(0, 3));
      for (int g = 0; g < ng; g++) idle_step(fs_noise, rd_fix);
      d = directed ? (32'hA000_0000 | 32'((s + i) % 8)) : $urandom;
      rwd = (rd_fix >= 0) ? rd_fix : (rd_fix == -2) ? cyc % 8 : int'($urandom % 8);
      step(1, d, err_pos == i, fs_noise && ($urandom % 3 == 0), $urandom % 8,
           (rd_fix != -1) ? 1'b1 : 1'($urandom % 2), rwd);
    end
    for (int j = 0; j < 10; j++) idle_step(fs_noise && j < 7, rd_fix);
  endtask

  task automatic do_reset();
    rd_q.delete(); arr_q.delete(); ld_q.delete();
    RSTN = 1'b0;
    FillVal = 0; FillStart = 0; RdReq = 0; FillErr = 0;
    fill_open = 1'b0; drain_left = 0; m_err = 1'b0;
    foreach (arrived[i]) arrived[i] = 1'b0;
    repeat (2) @(posedge CB);
    #1;
    RSTN = 1'b1;
  endtask

  initial begin
    do_reset();
    repeat (3) step(1, $urandom, 1, 0, 0, 1, $urandom % 8);
    fill(5, 1, -1, 0, 5, 0, 8);
    fill(5, 1, -1, 0, 4, 0, 8);
    fill(2, 0, 2, 0, -1, 0, 8);
    fill(0, 0, -1, 1, -1, 1, 8);
    fill(3, 0, -1, 0, -1, 0, 4);
    do_reset();
    fill(6, 0, -1, 0, -1, 0, 8);
    fill(1, 1, -1, 2, -2, 0, 8);
    fill(7, 0, 7, 1, -2, 0, 8);
    for (int k = 0; k < 20; k++) begin
      int ep;
      ep = ($urandom % 4 == 0) ? int'($urandom % 8) : -1;
      fill($urandom % 8, 0, ep, -1, -1, ep < 0, 8);
    end
    repeat (3) idle_step(0, -1);
    check("rd_q_empty", rd_q.size(), 0);
    check("arr_q_empty", arr_q.size(), 0);
    check("ld_q_empty", ld_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
